// File: rtl/output_vc_arbiter.sv
// Round-robin switch allocator for one router output port, with per-VC wormhole locks
// and downstream credit tracking. Optional idle-lock timeout: define OVA_LOCK_TIMEOUT_EN.
module output_vc_arbiter #(
    parameter int N_IN    = 5,
    parameter int N_VC    = 2,
    parameter int CREDITS = 4,
    parameter int CW      = 3
`ifdef OVA_LOCK_TIMEOUT_EN
    ,parameter int LOCK_TMO = 64
`endif
) (
    input  logic            clk,
    input  logic            RST_,
    input  logic [N_IN-1:0] REQ,
    input  logic [N_IN-1:0] REQ_VC,
    input  logic [N_IN-1:0] REQ_TAIL,
    input  logic [N_VC-1:0] IACK,
    output logic [N_IN-1:0] GNT,
    output logic [2:0]      OSEL,
    output logic            OVALID,
    output logic            OVCH,
    output logic [N_VC-1:0] OLCK,
    output logic [N_VC-1:0] CRED_AVAIL,
    output logic            CRED_ERR
`ifdef OVA_LOCK_TIMEOUT_EN
    ,output logic           LOCK_TMO_ERR
`endif
);

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    logic [2:0]      r_rr_ptr;
    logic [N_VC-1:0] r_lock;
    logic [2:0]      r_owner [N_VC];
    logic [CW-1:0]   r_cred  [N_VC];
    logic            r_cred_err;

    logic [N_IN-1:0] w_elig;
    logic            w_found;
    logic [2:0]      w_win;
    logic            w_vc;
    logic            w_tail;
    logic [N_VC-1:0] w_gv;

    // Saturating credit update: a return at full credit is ignored (flagged separately).
    function automatic logic [CW-1:0] cred_next(input logic [CW-1:0] c,
                                                input logic g, input logic a);
        case ({g, a})
            2'b10:   return c - CW'(1);
            2'b01:   return (c == CRED_MAX) ? c : c + CW'(1);
            default: return c;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            w_elig[i] = REQ[i] && (r_cred[REQ_VC[i]] != '0) &&
                        (!r_lock[REQ_VC[i]] || (r_owner[REQ_VC[i]] == 3'(i)));
        end
    end

    // No transfers while reset is asserted, even though requests may be present.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (!w_found && !RST_ && w_elig[(int'(r_rr_ptr) + k) % N_IN]) begin
                w_found = 1'b1;
                w_win   = 3'((int'(r_rr_ptr) + k) % N_IN);
            end
        end
    end

    assign w_vc   = REQ_VC[w_win];
    assign w_tail = REQ_TAIL[w_win];

    always_comb begin
        GNT = '0;
        if (w_found) GNT[w_win] = 1'b1;
        for (int v = 0; v < N_VC; v++) begin
            w_gv[v]       = w_found && (w_vc == 1'(v));
            CRED_AVAIL[v] = (r_cred[v] != '0);
        end
    end

    assign OSEL     = w_win;
    assign OVALID   = w_found;
    assign OVCH     = w_found & w_vc;
    assign OLCK     = r_lock;
    assign CRED_ERR = r_cred_err;

`ifdef OVA_LOCK_TIMEOUT_EN
    localparam int TW = (LOCK_TMO > 2) ? $clog2(LOCK_TMO) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(LOCK_TMO - 1);

    logic [TW-1:0] r_idle [N_VC];
    logic          r_tmo_err;
    logic [N_VC-1:0] w_tmo;

    always_comb begin
        for (int v = 0; v < N_VC; v++)
            w_tmo[v] = r_lock[v] && !w_gv[v] && (r_idle[v] == TMO_MAX);
    end

    always_ff @(posedge clk) begin
        if (RST_) begin
            r_tmo_err <= 1'b0;
            for (int v = 0; v < N_VC; v++) r_idle[v] <= '0;
        end else begin
            for (int v = 0; v < N_VC; v++) begin
                if (w_gv[v] || !r_lock[v] || w_tmo[v]) r_idle[v] <= '0;
                else                                   r_idle[v] <= r_idle[v] + TW'(1);
                if (w_tmo[v]) r_tmo_err <= 1'b1;
            end
        end
    end

    assign LOCK_TMO_ERR = r_tmo_err;
`endif

    always_ff @(posedge clk) begin
        if (RST_) begin
            r_rr_ptr   <= '0;
            r_lock     <= '0;
            r_cred_err <= 1'b0;
            for (int v = 0; v < N_VC; v++) begin
                r_owner[v] <= '0;
                r_cred[v]  <= CRED_MAX;
            end
        end else begin
            if (w_found) r_rr_ptr <= (w_win == 3'(N_IN - 1)) ? 3'd0 : w_win + 3'd1;
            for (int v = 0; v < N_VC; v++) begin
                r_cred[v] <= cred_next(r_cred[v], w_gv[v], IACK[v]);
                if (IACK[v] && !w_gv[v] && (r_cred[v] == CRED_MAX)) r_cred_err <= 1'b1;
                if (w_gv[v]) begin
                    if (!r_lock[v] && !w_tail) begin
                        r_lock[v]  <= 1'b1;
                        r_owner[v] <= w_win;
                    end else if (r_lock[v] && w_tail) begin
                        r_lock[v] <= 1'b0;
                    end
                end
`ifdef OVA_LOCK_TIMEOUT_EN
                else if (w_tmo[v]) begin
                    r_lock[v] <= 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_output_vc_arbiter.sv
// Scoreboard bench for output_vc_arbiter: expected grant/lock/credit state is queued
// as each cycle's stimulus is driven and compared at the following falling edge.
module tb_output_vc_arbiter;

    logic       clk = 1'b0;
    logic       RST_ = 1'b1;
    logic [4:0] REQ = '0, REQ_VC = '0, REQ_TAIL = '0;
    logic [1:0] IACK = '0;
    logic [4:0] GNT;
    logic [2:0] OSEL;
    logic       OVALID, OVCH, CRED_ERR;
    logic [1:0] OLCK, CRED_AVAIL;
`ifdef OVA_LOCK_TIMEOUT_EN
    logic       LOCK_TMO_ERR;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] gnt;
        logic [1:0] olck;
        logic [1:0] cav;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    output_vc_arbiter dut (
        .clk        (clk),
        .RST_       (RST_),
        .REQ        (REQ),
        .REQ_VC     (REQ_VC),
        .REQ_TAIL   (REQ_TAIL),
        .IACK       (IACK),
        .GNT        (GNT),
        .OSEL       (OSEL),
        .OVALID     (OVALID),
        .OVCH       (OVCH),
        .OLCK       (OLCK),
        .CRED_AVAIL (CRED_AVAIL),
        .CRED_ERR   (CRED_ERR)
`ifdef OVA_LOCK_TIMEOUT_EN
        ,.LOCK_TMO_ERR (LOCK_TMO_ERR)
`endif
    );

    task automatic do_reset();
        @(posedge clk); #1;
        RST_ = 1'b1; REQ = '0; REQ_VC = '0; REQ_TAIL = '0; IACK = '0;
        repeat (2) @(posedge clk);
        #1 RST_ = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        RST_ = 1'b1; REQ = 5'b11111; REQ_VC = '0; REQ_TAIL = 5'b11111; IACK = '0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) RST_ = 1'b0;
            exp_q.push_back('{(c == 2) ? 5'b00001 : 5'b00000, 2'b00, 2'b11});
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (GNT !== e.gnt) begin errors++; $display("FAIL reset_gnt[%0d]: got %b expected %b", c, GNT, e.gnt); end
            checks++;
            if (OLCK !== e.olck) begin errors++; $display("FAIL reset_olck[%0d]: got %b expected %b", c, OLCK, e.olck); end
            checks++;
            if (CRED_AVAIL !== e.cav) begin errors++; $display("FAIL reset_cav[%0d]: got %b expected %b", c, CRED_AVAIL, e.cav); end
            checks++;
            if ({OVALID, OSEL, OVCH, CRED_ERR} !== {(c == 2), 3'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_misc[%0d]: got valid=%b sel=%0d vch=%b err=%b", c, OVALID, OSEL, OVCH, CRED_ERR);
            end
            @(posedge clk); #1;
        end
        REQ = '0;
    endtask

    task automatic test_round_robin();
        do_reset();
        REQ = 5'b11111; REQ_VC = '0; REQ_TAIL = 5'b11111; IACK = 2'b01;
        for (int c = 0; c < 6; c++) begin
            exp_q.push_back('{5'b00001 << (c % 5), 2'b00, 2'b11});
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (GNT !== e.gnt) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, GNT, e.gnt); end
            checks++;
            if (OLCK !== e.olck) begin errors++; $display("FAIL rr_olck[%0d]: got %b expected %b", c, OLCK, e.olck); end
            checks++;
            if (OSEL !== 3'(c % 5)) begin errors++; $display("FAIL rr_osel[%0d]: got %0d expected %0d", c, OSEL, c % 5); end
            @(posedge clk); #1;
        end
        // A lone return now must overflow if the VC0 counter is still at 4.
        REQ = '0;
        @(posedge clk); #1;
        IACK = '0;
        @(negedge clk);
        checks++;
        if (CRED_ERR !== 1'b1) begin errors++; $display("FAIL rr_cred_full: got CRED_ERR=%b expected 1", CRED_ERR); end
    endtask

    task automatic test_wormhole();
        logic [4:0] t_req  [4] = '{5'b00100, 5'b00101, 5'b00101, 5'b00001};
        logic [4:0] t_tail [4] = '{5'b00001, 5'b00001, 5'b00101, 5'b00001};
        logic [4:0] t_gnt  [4] = '{5'b00100, 5'b00100, 5'b00100, 5'b00001};
        logic [1:0] t_olck [4] = '{2'b00, 2'b10, 2'b10, 2'b00};
        do_reset();
        REQ_VC = 5'b00101;
        for (int c = 0; c < 4; c++) begin
            REQ = t_req[c]; REQ_TAIL = t_tail[c];
            exp_q.push_back('{t_gnt[c], t_olck[c], 2'b11});
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (GNT !== e.gnt) begin errors++; $display("FAIL wh_gnt[%0d]: got %b expected %b", c, GNT, e.gnt); end
            checks++;
            if (OLCK !== e.olck) begin errors++; $display("FAIL wh_olck[%0d]: got %b expected %b", c, OLCK, e.olck); end
            checks++;
            if (CRED_AVAIL !== e.cav) begin errors++; $display("FAIL wh_cav[%0d]: got %b expected %b", c, CRED_AVAIL, e.cav); end
            if (c == 0) begin
                checks++;
                if ({OSEL, OVCH} !== {3'd2, 1'b1}) begin
                    errors++;
                    $display("FAIL wh_sel: got sel=%0d vch=%b expected sel=2 vch=1", OSEL, OVCH);
                end
            end
            @(posedge clk); #1;
        end
        REQ = '0;
    endtask

    task automatic test_credit_exhaust();
        do_reset();
        REQ = 5'b00010; REQ_VC = '0; REQ_TAIL = '0;
        for (int c = 0; c < 8; c++) begin
            IACK = (c == 5) ? 2'b01 : 2'b00;
            exp_q.push_back('{(c < 4 || c == 6) ? 5'b00010 : 5'b00000,
                              (c == 0) ? 2'b00 : 2'b01,
                              (c >= 4 && c != 6) ? 2'b10 : 2'b11});
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (GNT !== e.gnt) begin errors++; $display("FAIL cx_gnt[%0d]: got %b expected %b", c, GNT, e.gnt); end
            checks++;
            if (OLCK !== e.olck) begin errors++; $display("FAIL cx_olck[%0d]: got %b expected %b", c, OLCK, e.olck); end
            checks++;
            if (CRED_AVAIL !== e.cav) begin errors++; $display("FAIL cx_cav[%0d]: got %b expected %b", c, CRED_AVAIL, e.cav); end
            @(posedge clk); #1;
        end
        REQ = '0; IACK = '0;
    endtask

    task automatic test_cred_simul();
        do_reset();
        REQ = 5'b00010; REQ_VC = '0; REQ_TAIL = 5'b00010;
        for (int c = 0; c < 6; c++) begin
            IACK = (c == 3) ? 2'b01 : 2'b00;
            exp_q.push_back('{(c < 5) ? 5'b00010 : 5'b00000, 2'b00, (c == 5) ? 2'b10 : 2'b11});
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (GNT !== e.gnt) begin errors++; $display("FAIL cs_gnt[%0d]: got %b expected %b", c, GNT, e.gnt); end
            checks++;
            if (OLCK !== e.olck) begin errors++; $display("FAIL cs_olck[%0d]: got %b expected %b", c, OLCK, e.olck); end
            checks++;
            if (CRED_AVAIL !== e.cav) begin errors++; $display("FAIL cs_cav[%0d]: got %b expected %b", c, CRED_AVAIL, e.cav); end
            @(posedge clk); #1;
        end
        REQ = '0; IACK = '0;
        @(negedge clk);
        checks++;
        if (CRED_ERR !== 1'b0) begin errors++; $display("FAIL cs_err_pre: got %b expected 0", CRED_ERR); end
        @(posedge clk); #1;
        IACK = 2'b10;
        @(posedge clk); #1;
        IACK = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (CRED_ERR !== 1'b1) begin errors++; $display("FAIL cs_err_sticky[%0d]: got %b expected 1", c, CRED_ERR); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        REQ = 5'b01000; REQ_VC = '0; REQ_TAIL = '0;
        exp_q.push_back('{5'b01000, 2'b00, 2'b11});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (GNT !== e.gnt) begin errors++; $display("FAIL rm_head: got %b expected %b", GNT, e.gnt); end
        @(posedge clk); #1;
        REQ = 5'b10000; REQ_TAIL = 5'b10000; IACK = 2'b10;
        exp_q.push_back('{5'b00000, 2'b01, 2'b11});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (GNT !== e.gnt) begin errors++; $display("FAIL rm_blocked: got %b expected %b", GNT, e.gnt); end
        checks++;
        if (OLCK !== e.olck) begin errors++; $display("FAIL rm_olck_pre: got %b expected %b", OLCK, e.olck); end
        @(posedge clk); #1;
        RST_ = 1'b1; IACK = '0;
        @(negedge clk);
        checks++;
        if (GNT !== 5'b00000) begin errors++; $display("FAIL rm_in_reset: got %b expected 00000", GNT); end
        @(posedge clk); #1;
        RST_ = 1'b0;
        for (int c = 0; c < 5; c++) begin
            exp_q.push_back('{(c < 4) ? 5'b10000 : 5'b00000, 2'b00, (c < 4) ? 2'b11 : 2'b10});
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (GNT !== e.gnt) begin errors++; $display("FAIL rm_gnt[%0d]: got %b expected %b", c, GNT, e.gnt); end
            checks++;
            if (OLCK !== e.olck) begin errors++; $display("FAIL rm_olck[%0d]: got %b expected %b", c, OLCK, e.olck); end
            checks++;
            if (CRED_AVAIL !== e.cav) begin errors++; $display("FAIL rm_cav[%0d]: got %b expected %b", c, CRED_AVAIL, e.cav); end
            checks++;
            if (CRED_ERR !== 1'b0) begin errors++; $display("FAIL rm_err[%0d]: got %b expected 0", c, CRED_ERR); end
            @(posedge clk); #1;
        end
        REQ = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credit_exhaust();
        test_cred_simul();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_vc_arbiter.md
Name: output_vc_arbiter

Overview:
- Per-output-port switch allocator for the 5-port, 2-VC wormhole router.
- Selects one of N_IN input ports each cycle to drive the output link.
- Holds a VC lock from head flit to tail flit.
- Tracks downstream per-VC buffer credits returned on IACK; drives the output mux select and the OVALID/OVCH/OLCK strobes.

Parameters:
- N_IN, 5, number of requesting input ports
- N_VC, 2, number of virtual channels; REQ_VC is 1 bit, so only 2 is supported
- CREDITS, 4, downstream buffer depth per VC; reset value of each credit counter
- CW, 3, credit counter width; must satisfy 2^CW > CREDITS
- LOCK_TMO, 64, idle-owner timeout in cycles; used only with the optional feature

Ports:
- clk  in  1  clock
- RST_  in  1  reset, synchronous, active-high
- REQ  in  N_IN  per-input flit-ready request
- REQ_VC  in  N_IN  target VC of each input's current flit
- REQ_TAIL  in  N_IN  current flit is a tail; a head+tail flit sets it too
- IACK  in  N_VC  downstream credit return, 1 credit per VC per cycle
- GNT  out  N_IN  one-hot grant, combinational
- OSEL  out  3  binary index of the granted input; 0 when no grant
- OVALID  out  1  flit transferred this cycle (equals OR of GNT)
- OVCH  out  1  VC of the granted flit
- OLCK  out  N_VC  VC locked by an in-flight packet (registered)
- CRED_AVAIL  out  N_VC  credit counter of VC v is nonzero
- CRED_ERR  out  1  sticky flag: credit overflow seen

Behaviour:
- State, all registered:
  - rr_ptr, index 0..N_IN-1
  - per VC v: lock_st, IDLE or LOCKED
  - per VC v: owner, a port index
  - per VC v: cred, CW bits
  - CRED_ERR
- Reset, when RST_=1 at a posedge:
  - rr_ptr=0; all VCs IDLE; owner=0; cred=CREDITS; CRED_ERR=0.
  - Outputs therefore read GNT=0, OVALID=0, OSEL=0, OVCH=0, OLCK=0, CRED_AVAIL=all ones.
  - Reset mid-packet drops every lock and restores full credits; no packet state is preserved.
- Eligibility of input i, with v=REQ_VC[i]: all of the following must hold.
  - REQ[i]=1.
  - cred[v]>0.
  - Either lock_st[v]=IDLE, or lock_st[v]=LOCKED and owner[v]=i.
- Arbitration, combinational, zero latency:
  - Winner is the first eligible input found by scanning rr_ptr, rr_ptr+1, ... mod N_IN.
  - GNT is one-hot at the winner, or all zero if no input is eligible.
  - A flit transfers in any cycle with REQ[i]&GNT[i]; the requester advances its flit at that posedge.
- Updates on a posedge with a grant to input i on VC v:
  - rr_ptr <= (i+1) mod N_IN.
  - If v was IDLE and REQ_TAIL[i]=0: v goes LOCKED, owner[v] <= i.
  - If v was LOCKED and REQ_TAIL[i]=1: v goes IDLE.
  - Head+tail flit on an IDLE VC: v stays IDLE.
  - With no grant, rr_ptr holds.
- Credit counter per VC:
  - Grant on v and IACK[v] in the same cycle: cred unchanged.
  - Grant only: cred-1. The grant condition guarantees no underflow.
  - IACK only: cred+1, except when cred==CREDITS: hold and set CRED_ERR.
- Lock rules:
  - A locked VC blocks every other input on that VC, even when the owner is not requesting.
  - The owner may also win on the other VC; each VC is locked independently.
  - The same input may win back-to-back only if no other input is eligible, because rr_ptr moves past it.
- Only one flit per cycle on the output link. The two VCs share the link but keep separate lock and credit state.
- OLCK[v]=1 while lock_st[v]=LOCKED, and is cleared the cycle after the tail grant.

Optional Feature:
- Macro: OVA_LOCK_TIMEOUT_EN.
- When defined, each VC has an idle counter. It resets to 0 on any grant on v, and on entering LOCKED.
- While LOCKED with no grant on v, the counter increments.
- When it reaches LOCK_TMO-1, at the next posedge: lock_st[v] <= IDLE, and output LOCK_TMO_ERR (1 bit, sticky, cleared only by RST_) is set.
- When the macro is not defined: no idle counter, no LOCK_TMO_ERR port, and locks are held indefinitely until a tail flit.

Test Plan:
- Reset: hold RST_=1 for 2 cycles with all REQ=1 -> GNT=0, OLCK=00, CRED_AVAIL=11. First cycle after release: GNT=5'b00001, since rr_ptr=0.
- Round robin: all 5 inputs send single head+tail flits on VC0 (REQ=5'b11111, REQ_TAIL=all 1), IACK[0]=1 each cycle -> GNT sequence 00001, 00010, 00100, 01000, 10000, 00001. OLCK stays 00; cred[0] stays 4.
- Wormhole lock: input 2 sends a 3-flit packet on VC1 while input 0 also requests VC1 ->
  - GNT=00100 for 3 consecutive cycles; OLCK[1]=1 after the head.
  - Input 0 is granted the cycle after the tail; OLCK[1] drops.
- Credit exhaustion: no IACK, input 1 streams 5 non-tail flits on VC0 ->
  - 4 grants, then GNT=0 and CRED_AVAIL[0]=0.
  - One IACK[0] pulse -> exactly one more grant.
- Simultaneous grant+IACK at cred=1 -> cred stays 1. IACK[1] at cred=4 -> cred stays 4 and CRED_ERR=1 until reset.
- Reset mid-packet: input 3 locks VC0, then RST_ is pulsed for 1 cycle -> OLCK=00, cred=4. Input 4 on VC0 is granted in the first cycle after reset.
